// File: rtl/datamemory_be_if.sv
// datamemory_be_if: request/response bundle of the byte-enabled data memory.
//   master: drives EN, WR_RD, SIZE, SIGNED, ADDR and din. It observes dout,
//           dout_valid, misaligned and busy.
//   slave : the memory side, with the directions reversed.
interface datamemory_be_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  EN;
  logic                  WR_RD;
  logic [1:0]            SIZE;
  logic                  SIGNED;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  misaligned;
  logic                  busy;

  modport master (
    output EN, WR_RD, SIZE, SIGNED, ADDR, din,
    input  dout, dout_valid, misaligned, busy
  );

  modport slave (
    input  EN, WR_RD, SIZE, SIGNED, ADDR, din,
    output dout, dout_valid, misaligned, busy
  );
endinterface

// File: rtl/datamemory_be.sv
// datamemory_be: byte-addressed, little-endian data memory for the MEM stage.
// It handles byte, half and word loads and stores, with sign or zero
// extension on loads. It rejects misaligned accesses, and it can zero-fill
// the memory after reset.
//   Clk   : clock. All activity happens on the rising edge.
//   Rst_n : synchronous, active-low reset.
//   bus   : slave side of datamemory_be_if.
//           Requests : EN, WR_RD, SIZE, SIGNED, ADDR, din.
//           Responses: dout, dout_valid, misaligned, busy.
// Loads return one cycle after the sampling edge. Stores complete at the
// sampling edge.

// One byte lane of storage. The memory is four of these side by side, so
// each lane has its own write enable.
module datamemory_be_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [1<<AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module datamemory_be #(
  parameter int ADDR_WIDTH = 12,
  parameter int INIT_CLEAR = 1
) (
  input  logic            Clk,
  input  logic            Rst_n,
  datamemory_be_if.slave  bus
);
  localparam int WW        = ADDR_WIDTH - 2;
  localparam int DEPTH     = 1 << WW;
  localparam int NUM_LANES = 4;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] clr_cnt;
  logic          busy, clr_we;

  // ---------------- clear FSM ----------------
  always_ff @(posedge Clk)
    if (!Rst_n) state <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_cnt == WW'(DEPTH-1)) state_nxt = S_IDLE;
  end

  always_comb begin
    busy   = (state == S_CLEAR);
    clr_we = busy;
  end

  always_ff @(posedge Clk)
    if (!Rst_n)      clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;

  // ---------------- request decode ----------------
  logic [1:0]                      lane;
  logic [WW-1:0]                   widx;
  logic                            acc, legal, wr_go, ld_go;
  logic [NUM_LANES-1:0]            st_be;
  logic [NUM_LANES-1:0][7:0]       st_data;
  logic [NUM_LANES-1:0][7:0]       rd_word;

  assign lane  = bus.ADDR[1:0];
  assign widx  = bus.ADDR[ADDR_WIDTH-1:2];
  assign acc   = bus.EN & ~busy;
  // Rst_n gates the write so that a store sampled on a reset edge leaves no trace.
  assign wr_go = acc & bus.WR_RD & legal & Rst_n;
  assign ld_go = acc & ~bus.WR_RD;

  // Store data is replicated across lanes. The byte enables pick which lanes take it.
  always_comb begin
    legal   = 1'b0;
    st_be   = '0;
    st_data = {4{bus.din[7:0]}};
    case (bus.SIZE)
      2'b00: begin
        legal = 1'b1;
        st_be = 4'b0001 << lane;
      end
      2'b01: begin
        legal   = ~bus.ADDR[0];
        st_be   = bus.ADDR[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.din[15:0]}};
      end
      2'b10: begin
        legal   = (lane == 2'b00);
        st_be   = 4'hf;
        st_data = bus.din;
      end
      default: legal = 1'b0;
    endcase
  end

  // ---------------- storage ----------------
  // While clearing, the clear owns the write port. A store cannot be
  // accepted then, so the two never collide.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    datamemory_be_lane #(.AW(WW)) u_lane (
      .clk  (Clk),
      .we   ((clr_we & Rst_n) | (wr_go & st_be[i])),
      .waddr(clr_we ? clr_cnt : widx),
      .wdata(clr_we ? 8'h00 : st_data[i]),
      .raddr(widx),
      .rdata(rd_word[i])
    );
  end

  // ---------------- load extract ----------------
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;

  always_comb begin
    ld_b   = rd_word[lane];
    ld_h   = bus.ADDR[1] ? rd_word[3:2] : rd_word[1:0];
    ld_val = rd_word;
    case (bus.SIZE)
      2'b00:   ld_val = {{24{bus.SIGNED & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{bus.SIGNED & ld_h[15]}}, ld_h};
      default: ld_val = rd_word;
    endcase
  end

  // ---------------- response ----------------
  logic [31:0] dout_q;
  logic        dv_q, mis_q;

  always_ff @(posedge Clk)
    if (!Rst_n) begin
      dout_q <= '0;
      dv_q   <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      dv_q  <= ld_go;
      mis_q <= acc & ~legal;
      if (ld_go) dout_q <= legal ? ld_val : 32'h0;
    end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.misaligned = mis_q;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_datamemory_be.sv
// Testbench for datamemory_be with the default 4 KiB memory and the
// power-on clear enabled. The reference model is a flat byte array indexed
// by byte address. Loads and stores are modelled as byte-wise arithmetic
// on that array.
module tb_datamemory_be;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  datamemory_be_if #(.ADDR_WIDTH(12)) bus ();

  datamemory_be #(.ADDR_WIDTH(12), .INIT_CLEAR(1)) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem [4096];
  logic [31:0] exp_dout;
  logic [31:0] last_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
  endtask

  // One access, driven at a negedge and checked at the following negedge.
  // This leaves the bench on a negedge with EN low.
  task automatic op(input bit wr, input bit [1:0] sz, input bit sg,
                    input bit [11:0] a, input bit [31:0] d);
    bit          legal;
    int          nb;
    logic [31:0] val;
    legal = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'b00);
    nb    = 1 << sz;
    bus.EN = 1'b1; bus.WR_RD = wr; bus.SIZE = sz; bus.SIGNED = sg;
    bus.ADDR = a; bus.din = d;
    @(negedge clk);
    bus.EN = 1'b0;
    if (!wr) begin
      val = 32'h0;
      if (legal) begin
        for (int k = 0; k < nb; k++) val = val | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (sg && sz != 2'd2 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8 * nb));
      end
      exp_dout = val;
    end else if (legal) begin
      for (int k = 0; k < nb; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
    end
    chk("dout_valid", 32'(bus.dout_valid), 32'(!wr));
    chk("misaligned", 32'(bus.misaligned), 32'(!legal));
    chk("dout", bus.dout, exp_dout);
    last_dout = bus.dout;
  endtask

  // Counts the cycles in which busy is high, starting from the current
  // negedge. EN is pulsed (two stores, then two loads) partway through to
  // show that requests are ignored while clearing.
  task automatic count_busy(output int n, output int pulses);
    n = 0; pulses = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      bus.EN = (n >= 100 && n < 104); bus.WR_RD = (n < 102);
      bus.SIZE = 2'd2; bus.SIGNED = 1'b0; bus.ADDR = 12'h020; bus.din = 32'hFFFF_FFFF;
      @(negedge clk);
      n++;
      if (bus.dout_valid !== 1'b0 || bus.misaligned !== 1'b0) pulses++;
    end
    bus.EN = 1'b0;
  endtask

  int n, pulses;

  initial begin
    rst_n = 1'b0;
    bus.EN = 1'b0; bus.WR_RD = 1'b0; bus.SIZE = 2'd0; bus.SIGNED = 1'b0;
    bus.ADDR = '0; bus.din = '0;
    exp_dout = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst dout", bus.dout, 32'h0);
    chk("rst dout_valid", 32'(bus.dout_valid), 32'h0);
    chk("rst misaligned", 32'(bus.misaligned), 32'h0);
    chk("rst busy", 32'(bus.busy), 32'h1);

    // power-on clear
    rst_n = 1'b1;
    count_busy(n, pulses);
    chk("clear cycles", n, 1024);
    chk("pulses during busy", pulses, 0);
    model_zero();
    op(0, 2'd2, 0, 12'h020, 0); chk("no write while busy", last_dout, 32'h0);
    op(0, 2'd2, 0, 12'hFFC, 0); chk("top word cleared", last_dout, 32'h0);

    // word store
    op(1, 2'd2, 0, 12'h010, 32'h1234_5678);
    op(0, 2'd2, 0, 12'h010, 0); chk("word ld", last_dout, 32'h1234_5678);
    op(0, 2'd0, 0, 12'h013, 0); chk("ubyte ld 013", last_dout, 32'h0000_0012);
    op(0, 2'd1, 1, 12'h010, 0); chk("shalf ld 010", last_dout, 32'h0000_5678);
    // byte store
    op(1, 2'd0, 0, 12'h011, 32'h0000_008F);
    op(0, 2'd0, 1, 12'h011, 0); chk("sbyte ld 011", last_dout, 32'hFFFF_FF8F);
    op(0, 2'd0, 0, 12'h011, 0); chk("ubyte ld 011", last_dout, 32'h0000_008F);
    op(0, 2'd2, 0, 12'h010, 0); chk("word after byte", last_dout, 32'h1234_8F78);
    // half store
    op(1, 2'd1, 0, 12'h012, 32'h0000_BEEF);
    op(0, 2'd2, 0, 12'h010, 0); chk("word after half", last_dout, 32'hBEEF_8F78);
    op(0, 2'd1, 1, 12'h012, 0); chk("shalf ld 012", last_dout, 32'hFFFF_BEEF);
    op(0, 2'd1, 0, 12'h012, 0); chk("uhalf ld 012", last_dout, 32'h0000_BEEF);
    // misaligned
    op(1, 2'd2, 0, 12'h011, 32'hDEAD_BEEF);
    op(0, 2'd2, 0, 12'h011, 0); chk("misaligned ld dout", last_dout, 32'h0);
    op(0, 2'd2, 0, 12'h010, 0); chk("word intact", last_dout, 32'hBEEF_8F78);
    op(0, 2'd3, 0, 12'h000, 0);
    op(1, 2'd3, 0, 12'h000, 32'h1);

    // randomized traffic, concentrated on a small window to get overlap
    for (int i = 0; i < 400; i++) begin
      bit [11:0] a;
      a = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 63)) : 12'($urandom);
      op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle dout_valid", 32'(bus.dout_valid), 32'h0);
        chk("idle hold dout", bus.dout, exp_dout);
      end
    end

    // A load sampled on a reset edge is dropped.
    bus.EN = 1'b1; bus.WR_RD = 1'b0; bus.SIZE = 2'd2; bus.ADDR = 12'h010;
    rst_n = 1'b0;
    @(negedge clk);
    bus.EN = 1'b0;
    chk("ld at reset dv", 32'(bus.dout_valid), 32'h0);
    chk("ld at reset dout", bus.dout, 32'h0);
    chk("ld at reset busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("busy at 500", 32'(bus.busy), 32'h1);
    // reset mid-clear, with a load presented at the same time
    bus.EN = 1'b1; bus.WR_RD = 1'b0; bus.ADDR = 12'h010;
    rst_n = 1'b0;
    @(negedge clk);
    bus.EN = 1'b0;
    chk("midclear rst dv", 32'(bus.dout_valid), 32'h0);
    chk("midclear rst busy", 32'(bus.busy), 32'h1);
    rst_n = 1'b1;
    count_busy(n, pulses);
    chk("restart clear cycles", n, 1024);
    chk("pulses during restart", pulses, 0);
    model_zero();
    exp_dout = 32'h0;
    op(0, 2'd2, 0, 12'h010, 0); chk("cleared after restart", last_dout, 32'h0);
    op(1, 2'd0, 0, 12'h7FF, 32'h0000_00A5);
    op(0, 2'd0, 1, 12'h7FF, 0); chk("sbyte after restart", last_dout, 32'hFFFF_FFA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamemory_be.md
# datamemory_be

Parametrised byte-addressed data memory for the MIPS CPU. It supersedes the fixed 1024×32 word memory and supports byte, half-word and word loads and stores with signed or unsigned load extension. It detects misaligned accesses, gives reads a registered one-cycle latency, and runs an optional power-on clear sequence. It sits in the MEM stage between the ALU address output and the write-back mux.

## Interface
- ADDR_WIDTH, default 12: byte-address width. DEPTH = 2^(ADDR_WIDTH-2) 32-bit words, so the default is 1024 words.
- INIT_CLEAR, default 1: when 1, memory is zero-filled after reset. When 0, contents are undefined after reset and no clear runs.

Ports:
- Clk  in  1  clock. All activity on the rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- EN  in  1  access request, sampled at each edge.
- WR_RD  in  1  1 = store, 0 = load.
- SIZE  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- SIGNED  in  1  load extension: 1 = sign, 0 = zero. Ignored on stores.
- ADDR  in  ADDR_WIDTH  byte address.
- din  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dout  out  32  load result, extended to 32 bits.
- dout_valid  out  1  one-cycle pulse for each completed load, including misaligned loads.
- misaligned  out  1  one-cycle pulse for a rejected access.
- busy  out  1  clear sequence in progress. Requests are ignored while busy = 1.

## Operation
- Storage is little-endian. Word index = ADDR[ADDR_WIDTH-1:2]. Byte lane = ADDR[1:0]; lane 0 is din bits [7:0].
- FSM states: CLEAR, IDLE.
  - Reset edge: the FSM goes to CLEAR if INIT_CLEAR = 1, otherwise to IDLE. The clear counter resets to 0.
  - CLEAR: write 0 to word[counter], then increment the counter. After word DEPTH-1 is written, go to IDLE.
- An access is accepted when EN = 1 and the FSM is in IDLE.
- Alignment rules:
  - Byte access: always legal.
  - Half access: legal only when ADDR[0] = 0.
  - Word access: legal only when ADDR[1:0] = 0.
  - SIZE = 11: always misaligned.
- Legal store:
  - Byte: din[7:0] is written to lane ADDR[1:0].
  - Half: din[15:0] is written to lanes {ADDR[1],0} and {ADDR[1],1}.
  - Word: all 4 lanes are written.
  - Unaddressed lanes are preserved. dout and dout_valid are unaffected.
- Legal load: the selected byte or half is right-aligned, then sign- or zero-extended per SIGNED. Word loads ignore SIGNED.
- Misaligned access:
  - No memory write.
  - misaligned = 1 on the next cycle.
  - For a load, dout = 0 and dout_valid = 1 on the next cycle.
  - For a store, dout_valid = 0.
- dout holds its last value when no load completes.
- EN is ignored during CLEAR: no write, no response pulses.

## Timing
- Reset values: dout = 0, dout_valid = 0, misaligned = 0.
- busy after a reset edge: 1 if INIT_CLEAR = 1, else 0.
- Clear duration: busy is high for exactly DEPTH cycles after the first edge with Rst_n = 1. The edge with Rst_n = 0 does not count.
- Load latency is 1. A request sampled at edge k gives dout, dout_valid and misaligned during the cycle after edge k. Loads can be issued back-to-back, one per cycle.
- Store completes at the sampling edge. A load of the same word sampled at edge k+1 returns the new data; no bypass is required.
- Reset asserted mid-clear or mid-access: the pending response is dropped, all outputs take their reset values, and a clear restarts from word 0.
- Pulse outputs (dout_valid, misaligned) are high for exactly one cycle per accepted access.

## Test plan
- Reset with INIT_CLEAR = 1, release:
  - busy is high for exactly 1024 cycles, then drops.
  - A word load at 0xFFC returns 0x00000000 with dout_valid one cycle later.
  - EN pulsed during busy produces no dout_valid and no write.
- Word store 0x12345678 at 0x010:
  - Word load at 0x010 returns 0x12345678.
  - Unsigned byte load at 0x013 returns 0x00000012.
  - Signed half load at 0x010 returns 0x00005678.
- Byte store 0x8F at 0x011:
  - Signed byte load at 0x011 returns 0xFFFFFF8F.
  - Unsigned byte load at 0x011 returns 0x0000008F.
  - Word load at 0x010 returns 0x12348F78.
- Half store 0xBEEF at 0x012:
  - Word load at 0x010 returns 0xBEEF8F78.
  - Signed half load at 0x012 returns 0xFFFFBEEF.
  - Unsigned half load at 0x012 returns 0x0000BEEF.
- Misaligned accesses:
  - Word store 0xDEADBEEF at 0x011 pulses misaligned with no dout_valid.
  - Word load at 0x011 gives misaligned = 1, dout_valid = 1, dout = 0.
  - Word load at 0x010 is still 0xBEEF8F78.
  - SIZE = 11 at 0x000 pulses misaligned.
- Reset asserted at clear cycle 500:
  - busy stays high, and the count restarts at 0 on release (1024 further cycles).
  - A load issued before the reset gets no dout_valid.
